// File: rtl/cgp_eval_pkg.sv
// Shared types and default sizes for the CGP evaluation sequencer.
// Imported by the sequencer top and its popcount helper.
package cgp_eval_pkg;

   localparam int N_IN_DEF  = 9;
   localparam int N_OUT_DEF = 9;
   localparam int ERR_W_DEF = 13;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      COMPARE,
      DONE
   } state_t;

endpackage

// File: rtl/cgp_popcount.sv
// Combinational population count of a mismatch vector.
// Gives the Hamming weight of one pattern's output difference.
module cgp_popcount
   import cgp_eval_pkg::*;
#(
   parameter int N  = N_OUT_DEF,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  vec,
   output logic [CW-1:0] count
);

   // Sum the set bits of the vector.
   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/cgp_eval_sequencer.sv
// Exhaustive sweep sequencer comparing a candidate circuit to a golden one.
// Drives every input pattern, waits, and accumulates the Hamming distance.
module cgp_eval_sequencer
   import cgp_eval_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int N_OUT = N_OUT_DEF,
   parameter int ERR_W = ERR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [3:0]       settle_cycles,
   output logic [N_IN-1:0]  pi_vec,
   input  logic [N_OUT-1:0] cand_po,
   input  logic [N_OUT-1:0] gold_po,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [N_IN-1:0]  first_fail_pat
);

   localparam int CW = $clog2(N_OUT + 1);
   localparam logic [N_IN-1:0] LAST = '1;

   state_t        state;
   logic [3:0]    s_lat;
   logic [3:0]    s_cnt;
   logic [CW-1:0] weight;

   cgp_popcount #(
      .N  (N_OUT),
      .CW (CW)
   ) u_popcount (
      .vec   (cand_po ^ gold_po),
      .count (weight)
   );

   // Status flags decoded straight from the state register.
   assign busy = (state == DRIVE) || (state == SETTLE) || (state == COMPARE);
   assign done = (state == DONE);

   // Sweep control: pattern stepping, settle wait and error accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         pi_vec           <= '0;
         s_lat            <= '0;
         s_cnt            <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_pat   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state            <= DRIVE;
                  pi_vec           <= '0;
                  s_lat            <= settle_cycles;
                  err_count        <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_pat   <= '0;
               end
            end
            DRIVE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  s_cnt <= s_lat;
                  state <= (s_lat != 4'd0) ? SETTLE : COMPARE;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  s_cnt <= s_cnt - 4'd1;
                  if (s_cnt == 4'd1) state <= COMPARE;
               end
            end
            COMPARE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  err_count <= err_count + ERR_W'(weight);
                  if ((weight != '0) && !first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_pat   <= pi_vec;
                  end
                  if (pi_vec == LAST) begin
                     state <= DONE;
                  end else begin
                     pi_vec <= pi_vec + 1'b1;
                     state  <= DRIVE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cgp_eval_sequencer.sv
// Self-checking bench for the CGP evaluation sequencer.
// A timeline model predicts every output on every cycle.
module tb_cgp_eval_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] settle_cycles = 4'd0;
   logic [8:0] pi_vec;
   logic [8:0] cand_po;
   logic [8:0] gold_po;
   logic       busy;
   logic       done;
   logic [12:0] err_count;
   logic       first_fail_valid;
   logic [8:0] first_fail_pat;

   int tests = 0;
   int fails = 0;

   int         mode = 0;
   logic [8:0] mask [512];
   int         pre [513];
   int         ffidx = 512;

   bit m_run = 0;
   bit m_done = 0;
   int m_t = 0;
   int m_s = 0;
   int h_pi = 0;
   int h_err = 0;
   int h_ffv = 0;
   int h_ffp = 0;

   cgp_eval_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .abort            (abort),
      .settle_cycles    (settle_cycles),
      .pi_vec           (pi_vec),
      .cand_po          (cand_po),
      .gold_po          (gold_po),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count),
      .first_fail_valid (first_fail_valid),
      .first_fail_pat   (first_fail_pat)
   );

   always #5 clk = ~clk;

   // Candidate and golden circuits as pure functions of the driven pattern.
   assign gold_po = (mode == 2) ? 9'h1FF : 9'((pi_vec * 9'd37) ^ 9'h0A3);
   assign cand_po = (mode == 0) ? gold_po :
                    (mode == 1) ? (gold_po ^ 9'h001) :
                    (mode == 2) ? 9'h000 :
                    (mode == 3) ? ((pi_vec == 9'h1A5) ? (gold_po ^ 9'h005) : gold_po) :
                    (gold_po ^ mask[pi_vec]);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int weight_of(int m, int p);
      case (m)
         0: return 0;
         1: return 1;
         2: return 9;
         3: return (p == 'h1A5) ? 2 : 0;
         default: return $countones(mask[p]);
      endcase
   endfunction

   // Expected outputs from the position within the sweep timeline.
   function automatic void expect_now(output int pi, output int b, output int d,
                                      output int e, output int fv, output int fp);
      int len;
      int idx;
      if (m_run) begin
         len = 2 + m_s;
         idx = (m_t - 1) / len;
         pi = idx; b = 1; d = 0; e = pre[idx];
         fv = (ffidx < idx) ? 1 : 0;
         fp = fv ? ffidx : 0;
      end else if (m_done) begin
         pi = 511; b = 0; d = 1; e = pre[512];
         fv = (ffidx < 512) ? 1 : 0;
         fp = fv ? ffidx : 0;
      end else begin
         pi = h_pi; b = 0; d = 0; e = h_err; fv = h_ffv; fp = h_ffp;
      end
   endfunction

   // Model advance on each clock edge or reset.
   always @(posedge clk or posedge rst) begin
      int pi, b, d, e, fv, fp;
      if (rst) begin
         m_run = 0; m_done = 0; m_t = 0;
         h_pi = 0; h_err = 0; h_ffv = 0; h_ffp = 0;
      end else if (m_run) begin
         if (abort) begin
            expect_now(pi, b, d, e, fv, fp);
            h_pi = pi; h_err = e; h_ffv = fv; h_ffp = fp;
            m_run = 0;
         end else begin
            m_t++;
            if (m_t == 512 * (2 + m_s) + 1) begin
               m_run = 0;
               m_done = 1;
            end
         end
      end else if (m_done) begin
         expect_now(pi, b, d, e, fv, fp);
         h_pi = pi; h_err = e; h_ffv = fv; h_ffp = fp;
         m_done = 0;
      end else if (start && !abort) begin
         m_run = 1;
         m_t = 1;
         m_s = int'(settle_cycles);
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      int pi, b, d, e, fv, fp;
      if (!rst) begin
         expect_now(pi, b, d, e, fv, fp);
         check("pi_vec", 32'(pi_vec), pi);
         check("busy", 32'(busy), b);
         check("done", 32'(done), d);
         check("err_count", 32'(err_count), e);
         check("first_fail_valid", 32'(first_fail_valid), fv);
         check("first_fail_pat", 32'(first_fail_pat), fp);
      end
   end

   task automatic prep(input int m);
      @(posedge clk);
      #1;
      mode = m;
      for (int p = 0; p < 512; p++) begin
         if (m == 4)
            mask[p] = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h000;
         else
            mask[p] = 9'h000;
      end
      pre[0] = 0;
      ffidx = 512;
      for (int p = 0; p < 512; p++) begin
         pre[p + 1] = pre[p] + weight_of(m, p);
         if (ffidx == 512 && weight_of(m, p) != 0) ffidx = p;
      end
   endtask

   task automatic run_sweep(input int m, input int s, output int lat);
      int n;
      prep(m);
      @(negedge clk);
      start = 1'b1;
      settle_cycles = 4'(s);
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!done && n < 20000);
      if (n >= 20000) check("sweep_timeout", 32'(n), 0);
      lat = n + 1;
   endtask

   task automatic wait_pat(input int p);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (int'(pi_vec) != p && n < 20000);
      if (n >= 20000) check("pattern_wait_timeout", 32'(n), 0);
   endtask

   initial begin
      int lat;
      int s;
      for (int p = 0; p < 512; p++) mask[p] = 9'h000;
      for (int p = 0; p < 513; p++) pre[p] = 0;

      #12;
      check("rst_pi_vec", 32'(pi_vec), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err_count), 0);
      check("rst_ffv", 32'(first_fail_valid), 0);
      @(negedge clk);
      rst = 1'b0;

      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      check("start_abort_idle_busy", 32'(busy), 0);
      start = 1'b0;
      abort = 1'b0;

      run_sweep(0, 0, lat);
      check("equal_latency", 32'(lat), 1025);
      check("equal_err", 32'(err_count), 0);
      check("equal_ffv", 32'(first_fail_valid), 0);

      run_sweep(1, 0, lat);
      check("bit0_err", 32'(err_count), 512);
      check("bit0_ffp", 32'(first_fail_pat), 0);
      check("bit0_ffv", 32'(first_fail_valid), 1);

      run_sweep(2, 3, lat);
      check("allbits_latency", 32'(lat), 2561);
      check("allbits_err", 32'(err_count), 4608);

      run_sweep(3, int'($urandom_range(0, 3)), lat);
      check("single_err", 32'(err_count), 2);
      check("single_ffp", 32'(first_fail_pat), 32'h1A5);
      check("single_ffv", 32'(first_fail_valid), 1);

      prep(2);
      @(negedge clk);
      start = 1'b1;
      settle_cycles = 4'd3;
      @(negedge clk);
      start = 1'b0;
      wait_pat(5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_pat(16);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_err", 32'(err_count), 144);
      check("abort_pi", 32'(pi_vec), 16);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 0);
      end

      prep(1);
      @(negedge clk);
      start = 1'b1;
      settle_cycles = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_pat(40);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_pi_vec", 32'(pi_vec), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_err", 32'(err_count), 0);
      check("midrst_ffv", 32'(first_fail_valid), 0);
      check("midrst_ffp", 32'(first_fail_pat), 0);
      @(negedge clk);
      rst = 1'b0;
      run_sweep(1, 2, lat);
      check("postrst_latency", 32'(lat), 2049);
      check("postrst_err", 32'(err_count), 512);
      check("postrst_ffp", 32'(first_fail_pat), 0);

      for (int r = 0; r < 3; r++) begin
         s = int'($urandom_range(0, 3));
         run_sweep(4, s, lat);
         check("rand_latency", 32'(lat), 1 + 512 * (2 + s));
         check("rand_err", 32'(err_count), pre[512]);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cgp_eval_sequencer.md
CGP_EVAL_SEQUENCER -- requirements
Module: cgp_eval_sequencer

Interface
REQ-001 SHALL take parameter N_IN, default 9: width of the candidate/golden input vector; exhaustive sweep covers 2^N_IN patterns.
REQ-002 SHALL take parameter N_OUT, default 9: width of the candidate/golden output vector.
REQ-003 SHALL take parameter ERR_W, default 13: error counter width; the implementation SHALL require 2^N_IN*N_OUT < 2^ERR_W.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: request a full sweep; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: terminate a running sweep.
REQ-008 SHALL have port settle_cycles, input, 4: wait cycles inserted after each pattern is driven; sampled on start acceptance.
REQ-009 SHALL have port pi_vec, output, N_IN: registered pattern fed to both candidate and golden circuits.
REQ-010 SHALL have port cand_po, input, N_OUT: candidate circuit outputs.
REQ-011 SHALL have port gold_po, input, N_OUT: golden circuit outputs.
REQ-012 SHALL have port busy, output, 1: high in DRIVE, SETTLE and COMPARE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on sweep completion.
REQ-014 SHALL have port err_count, output, ERR_W: accumulated Hamming distance between cand_po and gold_po.
REQ-015 SHALL have port first_fail_valid, output, 1: a mismatching pattern has been recorded.
REQ-016 SHALL have port first_fail_pat, output, N_IN: first pattern with nonzero mismatch.

Function
REQ-017 SHALL implement states IDLE, DRIVE, SETTLE, COMPARE, DONE.
REQ-018 IDLE: start=1 and abort=0 at an edge -> DRIVE; pattern<=0, err_count<=0, first_fail_valid<=0, first_fail_pat<=0, settle value latched.
REQ-019 DRIVE: exactly 1 cycle; pi_vec=pattern; -> SETTLE if latched settle value S>0, else -> COMPARE; settle counter loaded with S.
REQ-020 SETTLE: exactly S cycles; counter decrements each cycle; -> COMPARE when counter reaches 1.
REQ-021 COMPARE: exactly 1 cycle; err_count += popcount(cand_po XOR gold_po) sampled this cycle; if popcount>0 and first_fail_valid=0, set first_fail_valid=1 and first_fail_pat=pattern.
REQ-022 COMPARE with pattern=2^N_IN-1 -> DONE; otherwise pattern+1 -> DRIVE.
REQ-023 DONE: done=1 for exactly 1 cycle -> IDLE; err_count, first_fail_* held until the next accepted start.
REQ-024 Latency: start accepted at edge k -> done high in cycle k+1+2^N_IN*(2+S).
REQ-025 pi_vec SHALL be stable from DRIVE through COMPARE of each pattern; it holds the last pattern in IDLE/DONE.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 abort=1 in DRIVE/SETTLE/COMPARE -> IDLE at the next edge; no done pulse; the COMPARE accumulation of that cycle is discarded; partial err_count and first_fail_* retained.
REQ-028 start and abort both high in IDLE -> stay IDLE (abort wins).
REQ-029 err_count SHALL never wrap (bound guaranteed by REQ-003); no saturation logic.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, pattern=0, pi_vec=0, settle counter=0, busy=0, done=0, err_count=0, first_fail_valid=0, first_fail_pat=0, independent of clk.
REQ-031 Reset mid-sweep SHALL discard all progress; first start after release begins at pattern 0.

Structure
REQ-032 Package cgp_eval_pkg SHALL hold the state enum and default N_IN, N_OUT, ERR_W constants.
REQ-033 A combinational sub-module cgp_popcount (N_OUT-bit vector -> count) SHALL compute the per-pattern mismatch weight.
REQ-034 All outputs SHALL be driven from registers or from state decode only; no combinational path from cand_po/gold_po to outputs.

Verification
REQ-035 cand_po=gold_po always, S=0, start at edge 0 -> done in cycle 1025, err_count=0, first_fail_valid=0.
REQ-036 cand_po=gold_po with bit0 inverted, S=0 -> err_count=512, first_fail_pat=0x000.
REQ-037 cand_po=0, gold_po=0x1FF, S=3 -> done in cycle 2561, err_count=4608.
REQ-038 Mismatch of 2 bits only at pattern 0x1A5 -> err_count=2, first_fail_pat=0x1A5, first_fail_valid=1.
REQ-039 abort at pattern 0x010 in SETTLE -> IDLE next edge, no done, err_count reflects patterns 0x000-0x00F only; start during sweep has no effect.
REQ-040 rst asserted mid-SETTLE between edges -> all outputs 0 immediately; subsequent start sweeps from 0x000 with correct totals.
